// File: rtl/debug_scan_master.sv
// JTAG scan initiator for the CPU debug slave's virtual-JTAG port.
// Each command runs one IR update, then DR capture, shift and update, and returns the captured DR bits.
module debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int CNT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        UIR,
        CDR,
        SDR,
        UDR,
        RTI
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DIV_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DR_WIDTH-1:0] shreg;
    logic                accept;
    logic                wrap;
    logic                tck_rise;
    logic                tck_fall;
    logic                last_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every state lasts whole tck periods, so transitions happen only on the falling tick.
    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        wrap           = (state != IDLE) && (div_cnt == DIV_LAST);
        tck_rise       = wrap && !tck;
        tck_fall       = wrap && tck;
        last_bit       = (bit_cnt == BIT_LAST);
        cmd_ready      = 1'b0;
        vs_uir         = 1'b0;
        vs_cdr         = 1'b0;
        vs_sdr         = 1'b0;
        vs_udr         = 1'b0;
        jtag_state_rti = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready      = 1'b1;
                jtag_state_rti = 1'b1;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = UIR;
                end
            end
            UIR: begin
                vs_uir = 1'b1;
                if (tck_fall) state_next = CDR;
            end
            CDR: begin
                vs_cdr = 1'b1;
                if (tck_fall) state_next = SDR;
            end
            SDR: begin
                vs_sdr = 1'b1;
                if (tck_fall && last_bit) state_next = UDR;
            end
            UDR: begin
                vs_udr = 1'b1;
                if (tck_fall) state_next = RTI;
            end
            RTI: begin
                jtag_state_rti = 1'b1;
                if (tck_fall) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: tdi launches on the falling tick, tdo and ir_out are captured on the rising tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            tck        <= 1'b0;
            tdi        <= 1'b0;
            ir_in      <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_ir_out <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == IDLE || wrap) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (wrap) tck <= ~tck;

            if (accept) begin
                shreg   <= cmd_data;
                ir_in   <= cmd_ir;
                bit_cnt <= '0;
                tdi     <= 1'b0;
            end

            if (tck_rise) begin
                if (state == CDR) rsp_ir_out <= ir_out;
                if (state == SDR) shreg <= {tdo, shreg[DR_WIDTH-1:1]};
            end

            if (tck_fall) begin
                case (state)
                    CDR: tdi <= shreg[0];
                    SDR: begin
                        if (last_bit) begin
                            tdi <= 1'b0;
                        end else begin
                            tdi     <= shreg[0];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    RTI: begin
                        rsp_data  <= shreg;
                        rsp_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debug_scan_master.sv
// Directed bench for debug_scan_master: expected responses are queued at command time
// and compared when rsp_valid appears; strobe widths and tck edges are measured on the way.
module tb_debug_scan_master;

    localparam int DRW = 38;
    localparam int IRW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [IRW-1:0] cmd_ir;
    logic [DRW-1:0] cmd_data;
    logic           rsp_valid;
    logic [DRW-1:0] rsp_data;
    logic [IRW-1:0] rsp_ir_out;
    logic           tck;
    logic           tdi;
    logic           tdo;
    logic [IRW-1:0] ir_in;
    logic [IRW-1:0] ir_out;
    logic           vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;
    logic           tdo_mode;

    logic           cmd_valid1;
    logic           cmd_ready1;
    logic [IRW-1:0] cmd_ir1;
    logic [DRW-1:0] cmd_data1;
    logic           rsp_valid1;
    logic [DRW-1:0] rsp_data1;
    logic [IRW-1:0] rsp_ir_out1;
    logic           tck1, tdi1, tdo1;
    logic [IRW-1:0] ir_in1;
    logic           vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1;

    int passed = 0;
    int total  = 0;

    logic [DRW-1:0] exp_data_q[$];
    logic [IRW-1:0] exp_ir_q[$];

    int lat, n_uir, n_cdr, n_sdr, n_udr, n_rise, rise0, rise1;

    always #5 clk = ~clk;

    assign tdo  = tdo_mode ? 1'b1 : tdi;
    assign tdo1 = tdi1;

    debug_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out), .tck(tck), .tdi(tdi),
        .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out), .vs_uir(vs_uir),
        .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
        .jtag_state_rti(jtag_state_rti)
    );

    debug_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_ir(cmd_ir1), .cmd_data(cmd_data1), .rsp_valid(rsp_valid1),
        .rsp_data(rsp_data1), .rsp_ir_out(rsp_ir_out1), .tck(tck1), .tdi(tdi1),
        .tdo(tdo1), .ir_in(ir_in1), .ir_out(2'b00), .vs_uir(vs_uir1),
        .vs_cdr(vs_cdr1), .vs_sdr(vs_sdr1), .vs_udr(vs_udr1),
        .jtag_state_rti(rti1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".tck"}, 64'(tck), 64'd0);
        check({tag, ".tdi"}, 64'(tdi), 64'd0);
        check({tag, ".ir_in"}, 64'(ir_in), 64'd0);
        check({tag, ".vs"}, 64'({vs_uir, vs_cdr, vs_sdr, vs_udr}), 64'd0);
        check({tag, ".rti"}, 64'(jtag_state_rti), 64'd1);
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, ".rsp_data"}, 64'(rsp_data), 64'd0);
        check({tag, ".rsp_ir_out"}, 64'(rsp_ir_out), 64'd0);
        check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    // Drives one command for a single clk and queues its expected response.
    task automatic applyStimulus(input logic [IRW-1:0] ir, input logic [DRW-1:0] data,
                                 input logic [DRW-1:0] exp_data, input logic [IRW-1:0] exp_ir);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_data  = data;
        exp_data_q.push_back(exp_data);
        exp_ir_q.push_back(exp_ir);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called at the first negedge after an accept; runs until rsp_valid, measuring on the way.
    task automatic checkOutput(input string tag, input int exp_lat);
        logic prev_tck;
        logic [DRW-1:0] ed;
        logic [IRW-1:0] ei;
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rise = 0;
        rise0 = -1; rise1 = -1;
        prev_tck = tck;
        for (lat = 0; lat < 2000; lat++) begin
            if (rsp_valid) break;
            n_uir += int'(vs_uir);
            n_cdr += int'(vs_cdr);
            n_sdr += int'(vs_sdr);
            n_udr += int'(vs_udr);
            if (tck && !prev_tck) begin
                if (vs_sdr) n_rise++;
                if (rise0 < 0) rise0 = lat;
                else if (rise1 < 0) rise1 = lat;
            end
            prev_tck = tck;
            @(negedge clk);
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        if (exp_data_q.size() == 0) begin
            check({tag, ".queue_empty"}, 64'd1, 64'd0);
        end else begin
            ed = exp_data_q.pop_front();
            ei = exp_ir_q.pop_front();
            check({tag, ".rsp_data"}, 64'(rsp_data), 64'(ed));
            check({tag, ".rsp_ir_out"}, 64'(rsp_ir_out), 64'(ei));
        end
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_ir     = '0;
        cmd_data   = '0;
        ir_out     = 2'b00;
        tdo_mode   = 1'b0;
        cmd_valid1 = 1'b0;
        cmd_ir1    = '0;
        cmd_data1  = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("post_reset");

        // Loopback with the default divider.
        applyStimulus(2'b01, 38'h15_DEAD_BEEF, 38'h15_DEAD_BEEF, 2'b00);
        check("loop.ir_in", 64'(ir_in), 64'h1);
        check("loop.rti_low", 64'(jtag_state_rti), 64'd0);
        checkOutput("loop", 336);

        // tdo stuck high, ir_out reported as 2'b11.
        tdo_mode = 1'b1;
        ir_out   = 2'b11;
        applyStimulus(2'b00, 38'h01_2345_6789, 38'h3F_FFFF_FFFF, 2'b11);
        checkOutput("ones", 336);
        tdo_mode = 1'b0;
        ir_out   = 2'b00;

        // Strobe widths, tck period and SDR edge count.
        applyStimulus(2'b10, 38'h0C_1234_5678, 38'h0C_1234_5678, 2'b00);
        check("strobe.ir_in_accept", 64'(ir_in), 64'h2);
        checkOutput("strobe", 336);
        check("strobe.vs_uir", 64'(n_uir), 64'd8);
        check("strobe.vs_cdr", 64'(n_cdr), 64'd8);
        check("strobe.vs_sdr", 64'(n_sdr), 64'd304);
        check("strobe.vs_udr", 64'(n_udr), 64'd8);
        check("strobe.sdr_rises", 64'(n_rise), 64'd38);
        check("strobe.tck_period", 64'(rise1 - rise0), 64'd8);
        check("strobe.ir_in_hold", 64'(ir_in), 64'h2);
        @(negedge clk);
        check("strobe.rsp_pulse", 64'(rsp_valid), 64'd0);
        check("strobe.tck_idle", 64'(tck), 64'd0);

        // Reset in the middle of the shift, after the tenth SDR rising edge.
        applyStimulus(2'b01, 38'h3A_5A5A_0F0F, 38'h3A_5A5A_0F0F, 2'b00);
        begin
            logic prev_tck;
            int   sdr_rises;
            int   guard;
            prev_tck  = tck;
            sdr_rises = 0;
            for (guard = 0; guard < 2000; guard++) begin
                if (tck && !prev_tck && vs_sdr) sdr_rises++;
                prev_tck = tck;
                if (sdr_rises == 10) break;
                @(negedge clk);
            end
            check("abort.reached_bit10", 64'(sdr_rises), 64'd10);
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("abort");
        reset = 1'b0;
        begin
            int saw_rsp;
            saw_rsp = 0;
            repeat (400) begin
                @(negedge clk);
                if (rsp_valid) saw_rsp++;
            end
            check("abort.no_rsp", 64'(saw_rsp), 64'd0);
        end
        exp_data_q.delete();
        exp_ir_q.delete();
        applyStimulus(2'b01, 38'h05_0505_A0A0, 38'h05_0505_A0A0, 2'b00);
        checkOutput("after_abort", 336);

        // cmd_valid held high across completion with a second payload.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = 2'b01;
        cmd_data  = 38'h2B_CAFE_F00D;
        exp_data_q.push_back(38'h2B_CAFE_F00D);
        exp_ir_q.push_back(2'b00);
        @(negedge clk);
        cmd_data = 38'h00_0000_0001;
        exp_data_q.push_back(38'h00_0000_0001);
        exp_ir_q.push_back(2'b00);
        check("b2b.busy_ready", 64'(cmd_ready), 64'd0);
        checkOutput("b2b_first", 336);
        check("b2b.ready_at_rsp", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        check("b2b.accepted_ready", 64'(cmd_ready), 64'd0);
        check("b2b.accepted_uir", 64'(vs_uir), 64'd1);
        cmd_valid = 1'b0;
        checkOutput("b2b_second", 336);

        // TCK_DIV=1 instance, loopback.
        @(negedge clk);
        cmd_valid1 = 1'b1;
        cmd_ir1    = 2'b01;
        cmd_data1  = 38'h2A_AAAA_AAAA;
        exp_data_q.push_back(38'h2A_AAAA_AAAA);
        @(negedge clk);
        cmd_valid1 = 1'b0;
        begin
            int l1;
            for (l1 = 0; l1 < 2000; l1++) begin
                if (rsp_valid1) break;
                @(negedge clk);
            end
            check("div1.latency", 64'(l1), 64'd84);
            if (exp_data_q.size() == 0) begin
                check("div1.queue_empty", 64'd1, 64'd0);
            end else begin
                check("div1.rsp_data", 64'(rsp_data1), 64'(exp_data_q.pop_front()));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/debug_scan_master.md
Name: debug_scan_master

Overview:
- Single-clock JTAG scan initiator that drives the virtual-JTAG-side signals of the CPU debug slave (tck, tdi, ir_in, uir/cdr/sdr/udr, rti) and receives tdo.
- Takes one command (IR value plus DR payload), performs one complete IR-update / DR-capture / DR-shift / DR-update sequence, and returns the captured DR bits.
- Used on-chip to exercise the debug slave (break, ocimem, trace control) without an external JTAG cable, and as a bench driver.

Parameters:
- DR_WIDTH, 38, DR shift length in bits (matches debug slave sr/jdo width).
- IR_WIDTH, 2, virtual IR width.
- TCK_DIV, 4, clk cycles per tck half-period; legal range is 1 or more.

Ports:
- clk  in  1  system clock; all logic is on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high while in IDLE; combinational from state.
- cmd_ir  in  IR_WIDTH  IR value to load.
- cmd_data  in  DR_WIDTH  DR payload; bit 0 is shifted first.
- rsp_valid  out  1  one-clk pulse; response valid.
- rsp_data  out  DR_WIDTH  captured tdo bits; first sample is bit 0.
- rsp_ir_out  out  IR_WIDTH  ir_out sampled during CDR.
- tck  out  1  generated scan clock.
- tdi  out  1  serial data to slave.
- tdo  in  1  serial data from slave.
- ir_in  out  IR_WIDTH  virtual IR presented to slave.
- ir_out  in  IR_WIDTH  slave IR status.
- vs_uir, vs_cdr, vs_sdr, vs_udr  out  1 each  virtual state strobes.
- jtag_state_rti  out  1  run-test-idle indication.

Behaviour:
- Reset values:
  - state IDLE, tck 0, tdi 0, ir_in 0, all vs_* 0, jtag_state_rti 1.
  - rsp_valid 0, rsp_data 0, rsp_ir_out 0, cmd_ready 1.
- Tick generator:
  - Divider counter 0..TCK_DIV-1; tck toggles when the counter wraps.
  - One tck period is 2*TCK_DIV clk cycles, low phase first.
  - The divider is held at 0 in IDLE.
- Phase timing:
  - Falling edge (start of low phase): state, vs_* and tdi update.
  - Rising edge (start of high phase): tdo and ir_out are sampled.
- Accept: when cmd_valid && cmd_ready, latch cmd_ir and cmd_data into a shift register, then go to UIR. In the same clk, ir_in <= cmd_ir and jtag_state_rti <= 0.
- States (each row: tck periods, active outputs):
  - IDLE: until accept; rti=1, no tck toggling.
  - UIR: 1 period; vs_uir=1.
  - CDR: 1 period; vs_cdr=1; ir_out sampled into rsp_ir_out on the rising edge.
  - SDR: DR_WIDTH periods; vs_sdr=1.
    - At each falling edge, tdi <= shreg[0].
    - At each rising edge, shreg <= {tdo, shreg[DR_WIDTH-1:1]}.
    - A bit counter counts 0..DR_WIDTH-1.
  - UDR: 1 period; vs_udr=1; tdi=0.
  - RTI: 1 period; jtag_state_rti=1.
  - At the end of RTI: rsp_data <= shreg, rsp_valid=1 for exactly one clk, return to IDLE with tck=0.
- Latency: accept clk to rsp_valid clk is (DR_WIDTH+4)*2*TCK_DIV clk cycles. Defaults give 336.
- ir_in holds its value after completion until the next accept.
- cmd_valid while busy is ignored; there is no queueing.
- A new command may be accepted in the clk after rsp_valid.
- Reset asserted mid-scan aborts immediately to the reset values; no rsp_valid is produced.
- TCK_DIV=1: tck toggles every clk; all rules above still hold.

Test Plan:
- Loopback (tdo tied to tdi), cmd_ir=2'b01, cmd_data=38'h15_DEAD_BEEF -> rsp_data=38'h15_DEAD_BEEF, rsp_valid exactly 336 clk after accept (TCK_DIV=4).
- tdo tied to 1, ir_out=2'b11, any payload -> rsp_data=38'h3F_FFFF_FFFF, rsp_ir_out=2'b11.
- cmd_ir=2'b10 -> ir_in=2'b10 from the accept clk onward, with strobe widths:
  - vs_uir high 8 clk, vs_cdr high 8 clk, vs_sdr high 304 clk, vs_udr high 8 clk.
  - tck period 8 clk; exactly 38 rising edges while vs_sdr=1.
- Reset pulse after the 10th SDR bit -> next clk all outputs at reset values, no rsp_valid; a following loopback command returns its payload intact.
- cmd_valid held high across completion with a second payload 38'h00_0000_0001 -> second command accepted in the clk after rsp_valid; mid-scan cmd_valid pulses are ignored (cmd_ready=0).
- TCK_DIV=1, loopback, payload 38'h2A_AAAA_AAAA -> rsp_data matches, latency 84 clk.
